// File: rtl/step_decoder_if.sv
// Sample stream into the step decoder and its lock/error status back out.
// Inputs qualified by in_vld; status is registered by the slave side.
interface step_decoder_if;
   logic        restart;
   logic        in_vld;
   logic [11:0] in_val;
   logic        locked;
   logic [1:0]  Xmode;
   logic [11:0] delta;
   logic        err;
   logic [7:0]  err_cnt;

   modport master (
      output restart, in_vld, in_val,
      input  locked, Xmode, delta, err, err_cnt
   );

   modport slave (
      input  restart, in_vld, in_val,
      output locked, Xmode, delta, err, err_cnt
   );
endinterface

// File: rtl/step_decoder.sv
// Locks onto a repeating counter step (0/1/4/8) and flags deviations; 1-cycle registered latency.
// No backpressure: every in_vld sample is consumed, idle cycles (in_vld=0) freeze all state.
module step_decoder #(
   parameter int LOCK_CNT = 4,
   parameter int MISS_MAX = 2
) (
   input  logic         clk,
   input  logic         rst,
   step_decoder_if.slave sif
);

   typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;

   state_t      state_q, state_d;
   logic [11:0] prev_q, prev_d;
   logic [11:0] delta_q, delta_d;
   logic        cand_vld_q, cand_vld_d;
   logic [1:0]  cand_q, cand_d;
   logic [3:0]  match_q, match_d;
   logic [3:0]  miss_q, miss_d;
   logic [1:0]  xmode_q, xmode_d;
   logic        locked_q, locked_d;
   logic        err_q, err_d;
   logic [7:0]  err_cnt_q, err_cnt_d;

   logic [11:0] diff;
   logic        legal;
   logic [1:0]  code;
   logic [11:0] lock_step;
   logic [3:0]  match_inc;
   logic [3:0]  miss_inc;
   logic [7:0]  err_cnt_inc;

   assign diff        = sif.in_val - prev_q;
   assign match_inc   = match_q + 4'd1;
   assign miss_inc    = miss_q + 4'd1;
   assign err_cnt_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

   always_comb begin
      legal = 1'b1;
      code  = 2'b00;
      case (diff)
         12'd0:   code = 2'b00;
         12'd1:   code = 2'b01;
         12'd4:   code = 2'b10;
         12'd8:   code = 2'b11;
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      case (xmode_q)
         2'b00:   lock_step = 12'd0;
         2'b01:   lock_step = 12'd1;
         2'b10:   lock_step = 12'd4;
         default: lock_step = 12'd8;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      prev_d     = prev_q;
      delta_d    = delta_q;
      cand_vld_d = cand_vld_q;
      cand_d     = cand_q;
      match_d    = match_q;
      miss_d     = miss_q;
      xmode_d    = xmode_q;
      locked_d   = locked_q;
      err_d      = 1'b0;
      err_cnt_d  = err_cnt_q;

      if (sif.restart) begin
         // Drop history but keep err_cnt and the last decoded Xmode.
         state_d    = IDLE;
         locked_d   = 1'b0;
         cand_vld_d = 1'b0;
         match_d    = 4'd0;
         miss_d     = 4'd0;
      end else if (sif.in_vld) begin
         case (state_q)
            IDLE: begin
               prev_d     = sif.in_val;
               state_d    = ACQ;
               cand_vld_d = 1'b0;
               match_d    = 4'd0;
            end
            ACQ: begin
               prev_d  = sif.in_val;
               delta_d = diff;
               if (legal) begin
                  if (cand_vld_q && code == cand_q) begin
                     match_d = match_inc;
                  end else begin
                     cand_d     = code;
                     cand_vld_d = 1'b1;
                     match_d    = 4'd1;
                  end
                  if (match_d == 4'(LOCK_CNT)) begin
                     state_d  = LOCK;
                     xmode_d  = cand_d;
                     locked_d = 1'b1;
                     miss_d   = 4'd0;
                  end
               end else begin
                  cand_vld_d = 1'b0;
                  match_d    = 4'd0;
                  err_d      = 1'b1;
                  err_cnt_d  = err_cnt_inc;
               end
            end
            LOCK: begin
               prev_d  = sif.in_val;
               delta_d = diff;
               if (diff == lock_step) begin
                  miss_d = 4'd0;
               end else begin
                  err_d     = 1'b1;
                  err_cnt_d = err_cnt_inc;
                  miss_d    = miss_inc;
                  if (miss_inc == 4'(MISS_MAX)) begin
                     state_d    = ACQ;
                     locked_d   = 1'b0;
                     cand_vld_d = 1'b0;
                     match_d    = 4'd0;
                     miss_d     = 4'd0;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         prev_q     <= 12'd0;
         delta_q    <= 12'd0;
         cand_vld_q <= 1'b0;
         cand_q     <= 2'b00;
         match_q    <= 4'd0;
         miss_q     <= 4'd0;
         xmode_q    <= 2'b00;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
         err_cnt_q  <= 8'd0;
      end else begin
         state_q    <= state_d;
         prev_q     <= prev_d;
         delta_q    <= delta_d;
         cand_vld_q <= cand_vld_d;
         cand_q     <= cand_d;
         match_q    <= match_d;
         miss_q     <= miss_d;
         xmode_q    <= xmode_d;
         locked_q   <= locked_d;
         err_q      <= err_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign sif.locked  = locked_q;
   assign sif.Xmode   = xmode_q;
   assign sif.delta   = delta_q;
   assign sif.err     = err_q;
   assign sif.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_step_decoder.sv
// Directed-vector bench for step_decoder with LOCK_CNT=4, MISS_MAX=2.
module tb_step_decoder;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   int   err_ones;
   int   locked_seen;

   step_decoder_if sif ();

   step_decoder #(.LOCK_CNT(4), .MISS_MAX(2)) dut (
      .clk (clk),
      .rst (rst),
      .sif (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic sample(input logic [11:0] v);
      @(negedge clk);
      sif.restart = 1'b0;
      sif.in_vld  = 1'b1;
      sif.in_val  = v;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      sif.restart = 1'b0;
      sif.in_vld  = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst         = 1'b1;
      sif.restart = 1'b0;
      sif.in_vld  = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_locked"},  32'(sif.locked),  32'd0);
      check({tag, "_xmode"},   32'(sif.Xmode),   32'd0);
      check({tag, "_delta"},   32'(sif.delta),   32'd0);
      check({tag, "_err"},     32'(sif.err),     32'd0);
      check({tag, "_err_cnt"}, 32'(sif.err_cnt), 32'd0);
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      rst         = 1'b1;
      sif.restart = 1'b0;
      sif.in_vld  = 1'b0;
      sif.in_val  = 12'd0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("por");
      do_reset();

      // Step 4 lock
      err_ones = 0;
      sample(12'd100); err_ones += int'(sif.err);
      sample(12'd104); err_ones += int'(sif.err);
      sample(12'd108); err_ones += int'(sif.err);
      sample(12'd112); err_ones += int'(sif.err);
      check("s4_not_locked_yet", 32'(sif.locked), 32'd0);
      sample(12'd116); err_ones += int'(sif.err);
      check("s4_locked", 32'(sif.locked), 32'd1);
      check("s4_xmode",  32'(sif.Xmode),  32'd2);
      check("s4_delta",  32'(sif.delta),  32'd4);
      check("s4_no_err", 32'(err_ones),   32'd0);
      idle_cycle();
      check("hold_delta",  32'(sif.delta),  32'd4);
      check("hold_locked", 32'(sif.locked), 32'd1);

      // Step 8 across the 12-bit wrap
      do_reset();
      sample(12'd4080);
      sample(12'd4088);
      sample(12'd0);
      check("wrap_delta", 32'(sif.delta), 32'd8);
      sample(12'd8);
      sample(12'd16);
      check("wrap_locked",  32'(sif.locked),  32'd1);
      check("wrap_xmode",   32'(sif.Xmode),   32'd3);
      check("wrap_delta2",  32'(sif.delta),   32'd8);
      check("wrap_err_cnt", 32'(sif.err_cnt), 32'd0);

      // Step 0 then a single deviation
      do_reset();
      repeat (5) sample(12'd50);
      check("s0_locked", 32'(sif.locked), 32'd1);
      check("s0_xmode",  32'(sif.Xmode),  32'd0);
      sample(12'd57);
      check("s0_err",         32'(sif.err),     32'd1);
      check("s0_err_cnt",     32'(sif.err_cnt), 32'd1);
      check("s0_still_lock",  32'(sif.locked),  32'd1);
      check("s0_delta",       32'(sif.delta),   32'd7);
      idle_cycle();
      check("s0_err_clear",   32'(sif.err),     32'd0);

      // Step 1, miss recovery then loss of lock
      do_reset();
      for (int v = 10; v <= 14; v++) sample(12'(v));
      check("s1_locked", 32'(sif.locked), 32'd1);
      check("s1_xmode",  32'(sif.Xmode),  32'd1);
      sample(12'd20);
      check("s1_miss_err",    32'(sif.err),    32'd1);
      check("s1_miss_locked", 32'(sif.locked), 32'd1);
      sample(12'd21);
      check("s1_recover_err", 32'(sif.err),    32'd0);
      sample(12'd30);
      check("s1_after30_locked", 32'(sif.locked), 32'd1);
      sample(12'd40);
      check("s1_unlock",        32'(sif.locked),  32'd0);
      check("s1_err_cnt",       32'(sif.err_cnt), 32'd3);
      check("s1_xmode_holds",   32'(sif.Xmode),   32'd1);

      // Saturation with illegal deltas in ACQ
      do_reset();
      sample(12'd0);
      err_ones    = 0;
      locked_seen = 0;
      for (int i = 0; i < 300; i++) begin
         sample((i % 2 == 0) ? 12'd3 : 12'd0);
         err_ones    += int'(sif.err);
         locked_seen += int'(sif.locked);
         if (i == 253) check("sat_cnt_254", 32'(sif.err_cnt), 32'd254);
         if (i == 254) check("sat_cnt_255", 32'(sif.err_cnt), 32'd255);
      end
      check("sat_err_pulses", 32'(err_ones),    32'd300);
      check("sat_err_cnt",    32'(sif.err_cnt), 32'd255);
      check("sat_never_lock", 32'(locked_seen), 32'd0);

      // Restart with a simultaneous sample, then reset mid-lock
      do_reset();
      for (int v = 200; v <= 204; v++) sample(12'(v));
      check("rs_locked", 32'(sif.locked), 32'd1);
      sample(12'd210);
      check("rs_err_cnt_pre", 32'(sif.err_cnt), 32'd1);
      @(negedge clk);
      sif.restart = 1'b1;
      sif.in_vld  = 1'b1;
      sif.in_val  = 12'd211;
      @(posedge clk);
      #1;
      check("rs_unlocked", 32'(sif.locked),  32'd0);
      check("rs_err",      32'(sif.err),     32'd0);
      check("rs_err_kept", 32'(sif.err_cnt), 32'd1);
      check("rs_delta",    32'(sif.delta),   32'd6);
      sample(12'd300);
      check("rs_idle_delta", 32'(sif.delta), 32'd6);
      sample(12'd301);
      check("rs_first_delta", 32'(sif.delta), 32'd1);
      sample(12'd302);
      sample(12'd303);
      sample(12'd304);
      check("rs_relock", 32'(sif.locked), 32'd1);
      @(negedge clk);
      rst         = 1'b1;
      sif.in_vld  = 1'b1;
      sif.in_val  = 12'd305;
      @(posedge clk);
      #1;
      check_reset_vals("midlock_rst");
      @(negedge clk);
      rst        = 1'b0;
      sif.in_vld = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
